// File: rtl/hazard_tracker_r0_if.sv
// hazard_tracker_r0_if
//   Bundles the pipeline-side signals of hazard_tracker_r0.
//   master : pipeline control (drives ID/EX info, mem_ready, flush; reads tags/stalls)
//   slave  : hazard_tracker_r0 itself
//   Inputs to tracker : id_valid, id_rs, id_rt, ex_writeReg, ex_regToWrite,
//                       ex_memRead, mem_ready, flush [, stall_cnt_clr]
//   Outputs of tracker: mem_writeReg, mem_regToWrite, wb_writeReg, wb_regToWrite,
//                       stall_if_id, bubble_ex, hold_back [, stall_cycles]
//   Optional macro HAZARD_STALL_COUNTER_EN adds stall_cnt_clr / stall_cycles.
interface hazard_tracker_r0_if #(
  parameter int REG_ADDR_WIDTH = 5
`ifdef HAZARD_STALL_COUNTER_EN
  , parameter int CNT_WIDTH = 16
`endif
);
  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic                      ex_writeReg;
  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite;
  logic                      ex_memRead;
  logic                      mem_ready;
  logic                      flush;
  logic                      mem_writeReg;
  logic [REG_ADDR_WIDTH-1:0] mem_regToWrite;
  logic                      wb_writeReg;
  logic [REG_ADDR_WIDTH-1:0] wb_regToWrite;
  logic                      stall_if_id;
  logic                      bubble_ex;
  logic                      hold_back;
`ifdef HAZARD_STALL_COUNTER_EN
  logic                      stall_cnt_clr;
  logic [CNT_WIDTH-1:0]      stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, ex_writeReg, ex_regToWrite, ex_memRead,
           mem_ready, flush, stall_cnt_clr,
    input  mem_writeReg, mem_regToWrite, wb_writeReg, wb_regToWrite,
           stall_if_id, bubble_ex, hold_back, stall_cycles
  );
  modport slave (
    input  id_valid, id_rs, id_rt, ex_writeReg, ex_regToWrite, ex_memRead,
           mem_ready, flush, stall_cnt_clr,
    output mem_writeReg, mem_regToWrite, wb_writeReg, wb_regToWrite,
           stall_if_id, bubble_ex, hold_back, stall_cycles
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, ex_writeReg, ex_regToWrite, ex_memRead,
           mem_ready, flush,
    input  mem_writeReg, mem_regToWrite, wb_writeReg, wb_regToWrite,
           stall_if_id, bubble_ex, hold_back
  );
  modport slave (
    input  id_valid, id_rs, id_rt, ex_writeReg, ex_regToWrite, ex_memRead,
           mem_ready, flush,
    output mem_writeReg, mem_regToWrite, wb_writeReg, wb_regToWrite,
           stall_if_id, bubble_ex, hold_back
  );
`endif
endinterface

// File: rtl/hazard_tracker_r0.sv
// hazard_tracker_r0
//   Producer-side companion to the forwarding unit of the pipelined MIPS core.
//   Carries the EX destination tag through EX/MEM and MEM/WB, detects load-use
//   hazards that forwarding cannot cover and freezes the back end while a load
//   waits on data memory.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous, active-low reset
//     bus  : hazard_tracker_r0_if.slave (ID/EX info in, write tags and stall
//            controls out)
//   Parameters: REG_ADDR_WIDTH, LOAD_LATENCY (1..7 bubble cycles),
//               CNT_WIDTH (only with the stall counter).
//   Optional macro HAZARD_STALL_COUNTER_EN adds a saturating stall-cycle counter
//   (bus.stall_cycles) with synchronous clear (bus.stall_cnt_clr).
module hazard_tracker_r0 #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_LATENCY   = 1
`ifdef HAZARD_STALL_COUNTER_EN
  , parameter int CNT_WIDTH    = 16
`endif
) (
  input logic                clk,
  input logic                rst,
  hazard_tracker_r0_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } state_t;

  state_t                    r_state;
  state_t                    w_stateNext;
  logic [2:0]                r_count;
  logic [2:0]                w_countNext;
  logic                      r_memWriteReg;
  logic [REG_ADDR_WIDTH-1:0] r_memRegToWrite;
  logic                      r_memMemRead;
  logic                      r_wbWriteReg;
  logic [REG_ADDR_WIDTH-1:0] r_wbRegToWrite;
  logic                      w_holdBack;
  logic                      w_haz;
  logic                      w_stallIfId;
  logic                      w_bubbleEx;

  // Only a load sitting in MEM can wait on data memory.
  assign w_holdBack = r_memMemRead & ~bus.mem_ready;

  assign w_haz = bus.id_valid & bus.ex_memRead & bus.ex_writeReg &
                 (bus.ex_regToWrite != '0) &
                 ((bus.id_rs == bus.ex_regToWrite) | (bus.id_rt == bus.ex_regToWrite));

  // Stall FSM state and remaining-bubble count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= RUN;
      r_count <= 3'd0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Next-state and stall controls. A pending memory wait always wins over a
  // load-use hazard; the hazard is simply re-evaluated once RUN resumes.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_stallIfId = 1'b0;
    w_bubbleEx  = 1'b0;
    case (r_state)
      RUN: begin
        if (w_holdBack) begin
          w_stateNext = MEM_WAIT;
        end else if (w_haz && !bus.flush) begin
          w_stallIfId = 1'b1;
          w_bubbleEx  = 1'b1;
          if (LOAD_LATENCY > 1) begin
            w_stateNext = LOAD_STALL;
            w_countNext = 3'(LOAD_LATENCY - 1);
          end
        end
      end
      LOAD_STALL: begin
        w_stallIfId = 1'b1;
        w_bubbleEx  = 1'b1;
        if (bus.flush) begin
          // The dependent instruction is squashed, so remaining bubbles are moot.
          w_countNext = 3'd0;
          w_stateNext = w_holdBack ? MEM_WAIT : RUN;
        end else if (w_holdBack) begin
          w_stateNext = MEM_WAIT;
        end else if (r_count <= 3'd1) begin
          w_countNext = 3'd0;
          w_stateNext = RUN;
        end else begin
          w_countNext = r_count - 3'd1;
        end
      end
      MEM_WAIT: begin
        w_stallIfId = 1'b1;
        if (bus.mem_ready) begin
          w_stateNext = (r_count != 3'd0) ? LOAD_STALL : RUN;
        end
      end
      default: begin
        w_stateNext = RUN;
        w_countNext = 3'd0;
      end
    endcase
    if (bus.flush) begin
      w_bubbleEx = 1'b1;
    end
  end

  // EX/MEM and MEM/WB tag registers. While held, MEM keeps its load and WB is
  // bubbled so the instruction already in WB is not written twice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_memWriteReg   <= 1'b0;
      r_memRegToWrite <= '0;
      r_memMemRead    <= 1'b0;
      r_wbWriteReg    <= 1'b0;
      r_wbRegToWrite  <= '0;
    end else if (!w_holdBack) begin
      if (w_bubbleEx) begin
        r_memWriteReg   <= 1'b0;
        r_memRegToWrite <= '0;
        r_memMemRead    <= 1'b0;
      end else begin
        r_memWriteReg   <= bus.ex_writeReg & (bus.ex_regToWrite != '0);
        r_memRegToWrite <= bus.ex_regToWrite;
        r_memMemRead    <= bus.ex_memRead;
      end
      r_wbWriteReg   <= r_memWriteReg;
      r_wbRegToWrite <= r_memRegToWrite;
    end else begin
      r_wbWriteReg <= 1'b0;
    end
  end

  assign bus.mem_writeReg   = r_memWriteReg;
  assign bus.mem_regToWrite = r_memRegToWrite;
  assign bus.wb_writeReg    = r_wbWriteReg;
  assign bus.wb_regToWrite  = r_wbRegToWrite;
  assign bus.stall_if_id    = w_stallIfId;
  assign bus.bubble_ex      = w_bubbleEx;
  assign bus.hold_back      = w_holdBack;

`ifdef HAZARD_STALL_COUNTER_EN
  logic [CNT_WIDTH-1:0] r_stallCycles;

  // Saturating count of cycles with IF/ID stalled; clear beats increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stallCycles <= '0;
    end else if (bus.stall_cnt_clr) begin
      r_stallCycles <= '0;
    end else if (w_stallIfId && !(&r_stallCycles)) begin
      r_stallCycles <= r_stallCycles + CNT_WIDTH'(1);
    end
  end

  assign bus.stall_cycles = r_stallCycles;
`endif

endmodule
